// File: rtl/modexp_ctrl_pkg.sv
// Shared types for the modular-exponentiation sequencer: FSM states and
// the operation selector (square vs. multiply-by-base).
package modexp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHK      = 3'd1,
    ST_OP_START = 3'd2,
    ST_OP_WAIT  = 3'd3,
    ST_FIN      = 3'd4
  } state_e;

  typedef enum logic {
    OP_SQR = 1'b0,
    OP_MUL = 1'b1
  } op_e;

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for r = m^e mod n. Drives one
// external serial modmult (CC cycles per multiply) and captures its product
// exactly CC edges after the start pulse has been seen.
module modexp_ctrl
  import modexp_ctrl_pkg::*;
#(
  parameter int N  = 8,
  parameter int CC = N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] m,
  input  logic [N-1:0] e,
  input  logic [N-1:0] n,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] r,
  output logic         mm_start,
  output logic [N-1:0] mm_x,
  output logic [N-1:0] mm_y,
  output logic [N-1:0] mm_n,
  input  logic [N-1:0] mm_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(CC);
  localparam logic [IW-1:0] IDX_TOP  = IW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CC - 1);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [N-1:0]   m_q, m_d, e_q, e_d, n_q, n_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bad_q, bad_d;      // operand check failed; reported as err in FIN
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [N-1:0]   r_q, r_d;
  logic           mm_start_q, mm_start_d;
  logic [N-1:0]   mm_x_q, mm_x_d, mm_y_q, mm_y_d, mm_n_q, mm_n_d;
  logic           go_fin, go_start;

  // Next-state logic; outputs are computed for the state being entered so
  // that every port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    m_d        = m_q;
    e_d        = e_q;
    n_d        = n_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    bad_d      = bad_q;
    done_d     = 1'b0;
    err_d      = err_q;
    r_d        = r_q;
    mm_start_d = 1'b0;
    mm_x_d     = mm_x_q;
    mm_y_d     = mm_y_q;
    mm_n_d     = mm_n_q;
    go_fin     = 1'b0;
    go_start   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = m;
          e_d     = e;
          n_d     = n;
          bad_d   = 1'b0;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (n_q == '0 || m_q >= n_q) begin
          bad_d  = 1'b1;
          acc_d  = '0;
          go_fin = 1'b1;
        end else if (n_q == N'(1)) begin
          acc_d  = '0;
          go_fin = 1'b1;
        end else begin
          acc_d    = N'(1);
          idx_d    = IDX_TOP;
          op_d     = OP_SQR;
          go_start = 1'b1;
        end
      end
      ST_OP_START: begin
        cnt_d   = '0;
        state_d = ST_OP_WAIT;
      end
      ST_OP_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          acc_d = mm_o;
          if (op_q == OP_SQR && e_q[idx_q]) begin
            op_d     = OP_MUL;
            go_start = 1'b1;
          end else if (idx_q == '0) begin
            go_fin = 1'b1;
          end else begin
            idx_d    = idx_q - IW'(1);
            op_d     = OP_SQR;
            go_start = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Launch the next multiply: operands stay frozen until the next launch.
    if (go_start) begin
      state_d    = ST_OP_START;
      mm_start_d = 1'b1;
      mm_x_d     = acc_d;
      mm_y_d     = (op_d == OP_SQR) ? acc_d : m_q;
      mm_n_d     = n_q;
    end

    // Finish: publish the result together with the one-cycle done pulse.
    if (go_fin) begin
      state_d = ST_FIN;
      done_d  = 1'b1;
      r_d     = acc_d;
      err_d   = bad_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // All state and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_SQR;
      m_q        <= '0;
      e_q        <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      bad_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      r_q        <= '0;
      mm_start_q <= 1'b0;
      mm_x_q     <= '0;
      mm_y_q     <= '0;
      mm_n_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      m_q        <= m_d;
      e_q        <= e_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      r_q        <= r_d;
      mm_start_q <= mm_start_d;
      mm_x_q     <= mm_x_d;
      mm_y_q     <= mm_y_d;
      mm_n_q     <= mm_n_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign r        = r_q;
  assign mm_start = mm_start_q;
  assign mm_x     = mm_x_q;
  assign mm_y     = mm_y_q;
  assign mm_n     = mm_n_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural serial modmult, golden modexp model,
// scoreboard of expected results/latencies checked on every done pulse.
module tb_modexp_ctrl;

  localparam int N  = 8;
  localparam int CC = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] m = '0, e = '0, n = '0;
  logic         busy, done, err;
  logic [N-1:0] r;
  logic         mm_start;
  logic [N-1:0] mm_x, mm_y, mm_n;
  logic [N-1:0] mm_o = '0;

  modexp_ctrl #(.N(N), .CC(CC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .e(e), .n(n),
    .busy(busy), .done(done), .err(err), .r(r),
    .mm_start(mm_start), .mm_x(mm_x), .mm_y(mm_y), .mm_n(mm_n), .mm_o(mm_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int mm_starts = 0;
  int stab_err = 0;
  logic [N-1:0] last_r;
  logic         last_err;

  typedef struct {
    logic [N-1:0] r;
    logic         err;
    int           lat;
    int           acc_cyc;
    logic [N-1:0] m, e, n;
  } exp_t;
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Golden r = m^e mod n with the error/latency rules of the sequencer.
  function automatic void gold(input logic [N-1:0] gm, input logic [N-1:0] ge,
                               input logic [N-1:0] gn, output logic [N-1:0] gr,
                               output logic gerr, output int glat);
    longint a;
    if (gn == 0 || gm >= gn) begin
      gr = '0; gerr = 1'b1; glat = 1;
    end else if (gn == 1) begin
      gr = '0; gerr = 1'b0; glat = 1;
    end else begin
      a = 1;
      for (int i = N - 1; i >= 0; i--) begin
        a = (a * a) % longint'(gn);
        if (ge[i]) a = (a * longint'(gm)) % longint'(gn);
      end
      gr = a[N-1:0]; gerr = 1'b0;
      glat = 1 + (N + $countones(ge)) * (CC + 1);
    end
  endfunction

  // Serial modmult model: product appears only for the capture edge,
  // a deliberately wrong value otherwise; also watches operand stability.
  int mdl_cnt = 0;
  bit mdl_act = 0;
  logic [N-1:0] mdl_x, mdl_y, mdl_n, mdl_p;
  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_act = 0;
      mm_o = '0;
    end else if (mm_start) begin
      mm_starts++;
      mdl_act = 1; mdl_cnt = 0;
      mdl_x = mm_x; mdl_y = mm_y; mdl_n = mm_n;
      if (mm_x >= mm_n || mm_y >= mm_n) stab_err++;
      mdl_p = (mm_n == 0) ? '0 : N'((int'(mm_x) * int'(mm_y)) % int'(mm_n));
      mm_o = mdl_p ^ N'($urandom_range(1, 255));
    end else if (mdl_act) begin
      mdl_cnt++;
      if (mdl_cnt <= CC && (mm_x !== mdl_x || mm_y !== mdl_y || mm_n !== mdl_n)) stab_err++;
      if (mdl_cnt == CC) mm_o = mdl_p;
      else begin
        mm_o = mdl_p ^ N'($urandom_range(1, 255));
        if (mdl_cnt > CC) mdl_act = 0;
      end
    end
  end

  // Scoreboard: push on an accepted request, pop and compare on done.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && start && !busy) begin
      x.m = m; x.e = e; x.n = n;
      gold(m, e, n, x.r, x.err, x.lat);
      x.acc_cyc = cyc + 1;
      sb_q.push_back(x);
    end
    if (rst_n && done) begin
      done_cnt++;
      last_r = r; last_err = err;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        x = sb_q.pop_front();
        $display("txn m=%0d e=%0d n=%0d r=%0d err=%0d lat=%0d (exp r=%0d err=%0d lat=%0d)",
                 x.m, x.e, x.n, r, err, cyc - x.acc_cyc, x.r, x.err, x.lat);
        chk("result_r", 32'(r), 32'(x.r));
        chk("result_err", 32'(err), 32'(x.err));
        chk("latency", 32'(cyc - x.acc_cyc), 32'(x.lat));
      end
    end
  end

  task automatic issue(input logic [N-1:0] im, input logic [N-1:0] ie, input logic [N-1:0] in_);
    @(posedge clk); #1;
    m = im; e = ie; n = in_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb_q.size() != 0 && t < 2000) begin
      @(posedge clk); t++;
    end
    chk(tag, 32'(sb_q.size()), 32'(0));
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_r"}, 32'(r), 0);
    chk({tag, "_mm_start"}, 32'(mm_start), 0);
    chk({tag, "_mm_x"}, 32'(mm_x), 0);
    chk({tag, "_mm_y"}, 32'(mm_y), 0);
    chk({tag, "_mm_n"}, 32'(mm_n), 0);
  endtask

  initial begin
    int ms0, dc0, t;

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Worked example and exponent zero
    issue(8'd4, 8'd13, 8'd187);
    drain("drain_4_13_187");
    chk("r_4_13_187", 32'(last_r), 32'd174);
    issue(8'd5, 8'd0, 8'd187);
    drain("drain_e0");
    chk("r_e0", 32'(last_r), 32'd1);

    // Operand errors / trivial modulus: no multiplies issued
    ms0 = mm_starts;
    issue(8'd200, 8'd3, 8'd187);
    drain("drain_m_ge_n");
    issue(8'd0, 8'd5, 8'd1);
    drain("drain_n1");
    issue(8'd7, 8'd5, 8'd0);
    drain("drain_n0");
    chk("no_mm_start_on_err", 32'(mm_starts), 32'(ms0));

    // Long run with stray start pulses while busy
    stab_err = 0;
    issue(8'd2, 8'hFF, 8'd251);
    for (int k = 0; k < 4; k++) begin
      repeat (20) @(posedge clk);
      #1 m = 8'd9; e = 8'd3; n = 8'd13; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    drain("drain_ff");
    chk("operand_stability", 32'(stab_err), 32'd0);

    // start held high through done: second request accepted right after FIN
    dc0 = done_cnt;
    @(posedge clk); #1;
    m = 8'd3; e = 8'd7; n = 8'd11; start = 1'b1;
    t = 0;
    while (done_cnt == dc0 && t < 500) begin @(posedge clk); t++; end
    @(posedge clk); #1 start = 1'b0;
    drain("drain_b2b");
    chk("b2b_done_count", 32'(done_cnt - dc0), 32'd2);

    // Asynchronous reset in the middle of OP_WAIT
    issue(8'd2, 8'hFF, 8'd251);
    t = 0;
    while (!mm_start && t < 50) begin @(posedge clk); t++; end
    chk("saw_mm_start", 32'(mm_start), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("midop_reset");
    sb_q.delete();
    dc0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("no_done_after_abort", 32'(done_cnt), 32'(dc0));
    issue(8'd2, 8'hFF, 8'd251);
    drain("drain_after_reset");
    chk("done_after_reset", 32'(done_cnt - dc0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
